sipo_rx: RTL and testbench



---
 rtl/sipo_rx.sv | 89 ++++++++
 tb/tb_sipo_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out frame receiver: start bit, WIDTH data bits MSB-first,
// optional even-parity bit and stop bit, all qualified by the bit enable sen.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sen,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             perr,
  output logic             ferr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             perr_pend;

  function automatic logic par_err(input logic [WIDTH-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  always_comb begin
    state_nx = state;
    if (sen) begin
      case (state)
        IDLE:    if (!sin) state_nx = DATA;
        DATA:    if (cnt == CW'(WIDTH - 1))
                   state_nx = (PARITY_EN != 0) ? PAR : STOP;
        PAR:     state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Strobes clear on every edge; everything else advances only on qualified bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      sreg      <= '0;
      perr_pend <= 1'b0;
      q         <= '0;
      valid     <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      if (sen) begin
        case (state)
          IDLE: cnt <= '0;
          DATA: begin
            sreg <= {sreg[WIDTH-2:0], sin};
            cnt  <= cnt + 1'b1;
          end
          PAR:  perr_pend <= par_err(sreg, sin);
          STOP: begin
            // A zero stop bit drops the frame and is not reused as a start bit.
            if (sin) begin
              q     <= sreg;
              valid <= 1'b1;
              perr  <= (PARITY_EN != 0) ? perr_pend : 1'b0;
            end else begin
              ferr  <= 1'b1;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: frame-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized frames with sen gaps.
module tb_sipo_rx;
  localparam int W  = 4;
  localparam int PE = 1;
  localparam int FL = W + PE + 1;  // bits after the start bit

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b1;
  logic         sen = 1'b0;
  logic [W-1:0] q;
  logic         valid, perr, ferr, busy;

  int tests = 0;
  int fails = 0;

  sipo_rx #(.WIDTH(W), .PARITY_EN(PE)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sen(sen),
    .q(q), .valid(valid), .perr(perr), .ferr(ferr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: collect sampled bits of a frame in a list, judge it whole.
  logic         m_in;
  int           m_n;
  logic         m_bits [0:15];
  logic [W-1:0] m_q;
  logic         m_valid, m_perr, m_ferr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_in = 0; m_n = 0; m_q = '0; m_valid = 0; m_perr = 0; m_ferr = 0;
    end else begin
      m_valid = 0;
      m_ferr  = 0;
      if (sen) begin
        if (!m_in) begin
          if (sin == 1'b0) begin m_in = 1; m_n = 0; end
        end else begin
          m_bits[m_n] = sin;
          m_n++;
          if (m_n == FL) begin
            logic [W-1:0] d;
            logic         px;
            m_in = 0;
            for (int i = 0; i < W; i++) d[W-1-i] = m_bits[i];
            px = 0;
            for (int i = 0; i < W; i++) px = px ^ d[i];
            if (m_bits[FL-1]) begin
              m_q = d; m_valid = 1;
              m_perr = (PE != 0) ? (px ^ m_bits[W]) : 1'b0;
            end else begin
              m_ferr = 1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_q",     32'(q),     32'(m_q));
    check("cyc_valid", 32'(valid), 32'(m_valid));
    check("cyc_perr",  32'(perr),  32'(m_perr));
    check("cyc_ferr",  32'(ferr),  32'(m_ferr));
    check("cyc_busy",  32'(busy),  32'(m_in));
  end

  int busy_cnt;

  task automatic send_bit(input logic b);
    sin = b; sen = 1'b1;
    @(negedge clk);
    if (busy) busy_cnt++;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      sen = 1'b0; sin = 1'($urandom);
      @(negedge clk);
      if (busy) busy_cnt++;
    end
  endtask

  // gaps < 0: random sen-low gaps between bits; otherwise a fixed count.
  task automatic send_word(input logic [W-1:0] d, input logic p, input logic stop, input int gaps);
    logic bits [0:FL];
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = d[W-1-i];
    if (PE != 0) bits[W+1] = p;
    bits[FL] = stop;
    for (int i = 0; i <= FL; i++) begin
      send_bit(bits[i]);
      if (i != FL) gap(gaps < 0 ? int'($urandom_range(0, 3)) : gaps);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk); @(negedge clk);
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Scenario 1: good frame 1011 with parity 1.
    busy_cnt = 0;
    send_word(4'b1011, 1'b1, 1'b1, 0);
    check("s1_q", 32'(q), 32'hB);
    check("s1_valid", 32'(valid), 32'h1);
    check("s1_perr", 32'(perr), 32'h0);
    check("s1_ferr", 32'(ferr), 32'h0);
    check("s1_busy_cycles", 32'(busy_cnt), 32'd6);
    send_bit(1'b1);
    check("s1_valid_fall", 32'(valid), 32'h0);

    // Scenario 2: bad parity still delivered, then a good frame.
    send_word(4'b1011, 1'b0, 1'b1, 0);
    check("s2_q", 32'(q), 32'hB);
    check("s2_perr", 32'(perr), 32'h1);
    send_word(4'b0011, 1'b0, 1'b1, 0);
    check("s2b_q", 32'(q), 32'h3);
    check("s2b_perr", 32'(perr), 32'h0);

    // Scenario 3: zero stop bit.
    send_word(4'b1111, 1'b0, 1'b0, 0);
    check("s3_ferr", 32'(ferr), 32'h1);
    check("s3_valid", 32'(valid), 32'h0);
    check("s3_q_hold", 32'(q), 32'h3);
    check("s3_idle", 32'(busy), 32'h0);

    // Scenario 4: sen pattern 1,0,0,1 with junk in the gaps.
    send_word(4'b1011, 1'b1, 1'b1, 2);
    check("s4_q", 32'(q), 32'hB);
    check("s4_valid", 32'(valid), 32'h1);

    // Scenario 5: reset mid-frame.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #3 rst = 1'b0;
    #1;
    check("s5_rst_q", 32'(q), 32'h0);
    check("s5_rst_busy", 32'(busy), 32'h0);
    check("s5_rst_valid", 32'(valid | ferr | perr), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    send_word(4'b0011, 1'b0, 1'b1, 0);
    check("s5_q", 32'(q), 32'h3);
    check("s5_valid", 32'(valid), 32'h1);

    // Scenario 6: back-to-back frames.
    send_word(4'b1011, 1'b1, 1'b1, 0);
    check("s6a_q", 32'(q), 32'hB);
    check("s6a_valid", 32'(valid), 32'h1);
    send_word(4'b0110, 1'b0, 1'b1, 0);
    check("s6b_q", 32'(q), 32'h6);
    check("s6b_valid", 32'(valid), 32'h1);
    check("s6b_perr", 32'(perr), 32'h0);

    // Randomized frames: parity and stop errors, sen gaps, idle ones between frames.
    for (int f = 0; f < 300; f++) begin
      logic [W-1:0] d;
      logic p, st;
      d  = W'($urandom);
      p  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      st = ($urandom_range(0, 7) != 0);
      send_word(d, p, st, -1);
      if (st) begin
        check("rnd_q", 32'(q), 32'(d));
        check("rnd_valid", 32'(valid), 32'h1);
      end else begin
        check("rnd_ferr", 32'(ferr), 32'h1);
      end
      for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
        if ($urandom_range(0, 1) == 1) send_bit(1'b1);
        else gap(1);
      end
    end

    send_bit(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
